// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned RK_IDX_W  = 4;
    localparam int unsigned AES_NR    = 10;

    typedef logic [AES_BLK_W-1:0] aes_block_t;
    typedef logic [RK_IDX_W-1:0]  rk_idx_t;

    function automatic logic idx_in_range(rk_idx_t idx, int unsigned nr);
        return 32'(idx) <= nr;
    endfunction

endpackage

// File: rtl/inv_ark_key_table.sv
// Expanded round-key storage: one write port, one combinational read port.
module inv_ark_key_table
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [RK_IDX_W-1:0]  waddr,
    input  logic [AES_BLK_W-1:0] wdata,
    input  logic [RK_IDX_W-1:0]  raddr,
    output logic [AES_BLK_W-1:0] rdata,
    output logic                 raddr_oob,
    output logic                 waddr_oob
);

    aes_block_t keys_q [NR+1];

    logic waddr_ok;

    assign waddr_ok  = idx_in_range(waddr, NR);
    assign waddr_oob = we && !waddr_ok;
    assign raddr_oob = !idx_in_range(raddr, NR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(NR); i++) begin
                keys_q[i] <= '0;
            end
        end else if (we && waddr_ok) begin
            keys_q[waddr] <= wdata;
        end
    end

    // Reads see the registered array, so a same-cycle write returns the old key.
    always_comb begin
        rdata = '0;
        if (!raddr_oob) begin
            rdata = keys_q[raddr];
        end
    end

endmodule

// File: rtl/inv_ark_stage.sv
// Two-stage valid/ready AddRoundKey stage for the inverse cipher, feeding inv_mixcolumns.
module inv_ark_stage
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_we,
    input  logic [RK_IDX_W-1:0]  key_waddr,
    input  logic [AES_BLK_W-1:0] key_wdata,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic [RK_IDX_W-1:0]  in_round,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_mix,
    output logic                 out_last,
    output logic                 err
);

    logic       ready_en_q;
    logic       a_valid_q;
    aes_block_t a_data_q;
    rk_idx_t    a_round_q;

    logic       out_valid_q;
    aes_block_t out_data_q;
    logic       out_mix_q;
    logic       out_last_q;
    logic       err_q;

    aes_block_t rd_key;
    logic       rd_oob;
    logic       wr_oob;
    logic       adv;
    logic       in_fire;
    logic       move;
    logic       mix_d;
    logic       last_d;

    inv_ark_key_table #(
        .NR(NR)
    ) u_key_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (key_we),
        .waddr     (key_waddr),
        .wdata     (key_wdata),
        .raddr     (a_round_q),
        .rdata     (rd_key),
        .raddr_oob (rd_oob),
        .waddr_oob (wr_oob)
    );

    assign adv      = !out_valid_q || out_ready;
    assign move     = a_valid_q && adv;
    // ready_en_q keeps in_ready low throughout reset without a combinational reset path.
    assign in_ready = ready_en_q && (!a_valid_q || adv);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        mix_d  = 1'b0;
        last_d = 1'b0;
        if (!rd_oob) begin
            mix_d  = (32'(a_round_q) >= 32'd1) && (32'(a_round_q) <= NR - 1);
            last_d = (a_round_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            a_valid_q  <= 1'b0;
            a_data_q   <= '0;
            a_round_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (in_fire) begin
                a_valid_q <= 1'b1;
                a_data_q  <= in_data;
                a_round_q <= in_round;
            end else if (move) begin
                a_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mix_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (move) begin
            out_valid_q <= 1'b1;
            out_data_q  <= a_data_q ^ rd_key;
            out_mix_q   <= mix_d;
            out_last_q  <= last_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (wr_oob || (move && rd_oob)) begin
            err_q <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mix   = out_mix_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule
